multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle sequencer for the RISC-V core. It replaces the single-cycle combinational decode with a Moore-style state machine that walks each instruction through fetch, decode, execute, memory and writeback. Each step drives the shared ALU, unified memory port, register file and PC. It sits beside the datapath, takes the opcode from the instruction register plus ALU `zero`, and emits every mux select and write enable each cycle.

## Interface
Parameters:
- none (encodings fixed below)

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  7  IR[6:0], valid from DECODE onward
- `zero`  in  1  ALU zero flag, sampled in BEQ
- `mem_ready`  in  1  memory completion strobe (used only with MEM_WAIT_EN)
- `pc_write`  out  1  PC load enable
- `ir_write`  out  1  instruction register load enable
- `adr_src`  out  1  memory address: 0=PC, 1=ALU result register
- `mem_read_en`  out  1  memory read strobe
- `mem_write_en`  out  1  memory write strobe
- `reg_write_en`  out  1  register file write enable
- `result_src`  out  2  00=ALU out reg, 01=mem data reg, 10=ALU result direct
- `alu_src_a`  out  2  00=PC, 01=old PC, 10=rs1
- `alu_src_b`  out  2  00=rs2, 01=immediate, 10=constant 4
- `alu_op`  out  2  00=add, 01=sub/compare, 10=R-type funct, 11=I-type funct
- `branch`  out  1  high in BEQ state
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction
- `halted`  out  1  high in TRAP
- `state`  out  4  current state encoding, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
- Any output not listed for a state is 0.
- FETCH: mem_read_en=1, adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precomputed). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD for load, MEMWRITE for store. Opcode is re-examined here.
- MEMREAD: mem_read_en=1, adr_src=1. Next state is MEMWB.
- MEMWB: result_src=01, reg_write_en=1, instr_done=1. Next state is FETCH.
- MEMWRITE: mem_write_en=1, adr_src=1, instr_done=1. Next state is FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=11. Next state is ALUWB.
- ALUWB: result_src=00, reg_write_en=1, instr_done=1. Next state is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state is ALUWB, which writes the link address.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, pc_write=zero (Mealy term), instr_done=1. Next state is FETCH.
- TRAP: halted=1, all strobes 0. The FSM stays in TRAP until reset; opcode changes are ignored.

## Timing
- Reset: asynchronous entry into FETCH while rst_n=0. Outputs then show the FETCH values (pc_write=1, ir_write=1, mem_read_en=1, ...).
  - Datapath registers are also held in reset, so these strobes have no effect.
- Reset asserted mid-instruction aborts the instruction immediately. No partial writeback completes after rst_n falls.
- First FETCH occurs on the first rising edge after rst_n rises.
- Cycles per instruction without memory waits:
  - beq: 3
  - R-type, I-type, store, jal: 4
  - load: 5
- instr_done and the writeback strobe share the same cycle. Architectural state is committed at the edge closing that cycle.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0, keeping their strobes asserted.
  - In FETCH, pc_write and ir_write are gated to mem_ready; in MEMWRITE, instr_done is gated to mem_ready.
  - The state advances on the edge where mem_ready=1.
  - mem_ready=1 on the first cycle gives zero added latency.
- `MEM_WAIT_EN` undefined: mem_ready is ignored, every state lasts exactly one cycle, and the timings above apply.

## Test plan
- Reset, then R-type (opcode 0110011) → states 0,1,6,8,0. reg_write_en=1 only in state 8, instr_done pulses once, 4 cycles.
- Load (0000011) then store (0100011) → load traverses 0,1,2,3,4 with result_src=01 in MEMWB. Store traverses 0,1,2,5 with mem_write_en=1 exactly one cycle.
- BEQ (1100011) with zero=1, then with zero=0 → pc_write high in state 9 only when zero=1. 3 cycles each.
- JAL (1101111) → pc_write in states 0 and 10, reg_write_en in state 8 with result_src=00.
- Opcode 0000000 → TRAP (state 15), halted=1, all strobes 0 for 20 cycles. rst_n pulse returns the FSM to state 0.
- MEM_WAIT_EN, mem_ready low 3 cycles in FETCH → FSM stays in FETCH 4 cycles, pc_write/ir_write high only in the 4th. rst_n dropped during MEMREAD → state 0 immediately, no reg_write_en.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       reg_write_en;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       branch;
  logic       instr_done;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, adr_src,
    output mem_read_en, mem_write_en,
    output reg_write_en, result_src,
    output alu_src_a, alu_src_b, alu_op,
    output branch, instr_done, halted,
    output state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, adr_src,
    input  mem_read_en, mem_write_en,
    input  reg_write_en, result_src,
    input  alu_src_a, alu_src_b, alu_op,
    input  branch, instr_done, halted,
    input  state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore-style multi-cycle sequencer: fetch/decode/exec/mem/writeback.
// Optional MEM_WAIT_EN: stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_control_fsm (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  state_t cur;
  state_t nxt;
  logic   ready;

`ifdef MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign ready = 1'b1;
`endif

  logic is_load;
  logic is_store;
  logic is_rtype;
  logic is_itype;
  logic is_beq;
  logic is_jal;

  assign is_load  = (bus.opcode == 7'b0000011);
  assign is_store = (bus.opcode == 7'b0100011);
  assign is_rtype = (bus.opcode == 7'b0110011);
  assign is_itype = (bus.opcode == 7'b0010011);
  assign is_beq   = (bus.opcode == 7'b1100011);
  assign is_jal   = (bus.opcode == 7'b1101111);

  assign bus.state = cur;

  // State register; reset aborts any instruction and parks in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state selection
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:    if (ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_load,
          is_store: nxt = S_MEMADR;
          is_rtype: nxt = S_EXECR;
          is_itype: nxt = S_EXECI;
          is_beq:   nxt = S_BEQ;
          is_jal:   nxt = S_JAL;
          default:  nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   nxt = is_store ? S_MEMWRITE
                                 : S_MEMREAD;
      S_MEMREAD:  if (ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (ready) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  // Per-state control outputs (BEQ pc_write is the only Mealy term)
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.adr_src      = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.result_src   = 2'b00;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.alu_op       = 2'b00;
    bus.branch       = 1'b0;
    bus.instr_done   = 1'b0;
    bus.halted       = 1'b0;
    unique case (cur)
      S_FETCH: begin
        bus.mem_read_en = 1'b1;
        bus.ir_write    = ready;
        bus.alu_src_b   = 2'b10;
        bus.result_src  = 2'b10;
        bus.pc_write    = ready;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        bus.mem_read_en = 1'b1;
        bus.adr_src     = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src   = 2'b01;
        bus.reg_write_en = 1'b1;
        bus.instr_done   = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_write_en = 1'b1;
        bus.adr_src      = 1'b1;
        bus.instr_done   = ready;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b11;
      end
      S_ALUWB: begin
        bus.reg_write_en = 1'b1;
        bus.instr_done   = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_op     = 2'b01;
        bus.branch     = 1'b1;
        bus.pc_write   = bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      S_TRAP: begin
        bus.halted = 1'b1;
      end
      default: begin
        bus.halted = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Instruction-level reference model with randomized zero/mem_ready.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int seq[$];

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Expected control word for a state, straight from the state table
  function automatic logic [16:0] exp_ctrl(
    int st, logic z, logic rdy);
    logic pcw, irw, adr, mr, mw, rw, br, dn, hl;
    logic [1:0] rs, sa, sb, op;
    logic g;
    g = WAIT_EN ? rdy : 1'b1;
    {pcw, irw, adr, mr, mw, rw, br, dn, hl} = '0;
    {rs, sa, sb, op} = '0;
    case (st)
      0: begin
        mr = 1; irw = g; sb = 2'b10;
        rs = 2'b10; pcw = g;
      end
      1: begin sa = 2'b01; sb = 2'b01; end
      2: begin sa = 2'b10; sb = 2'b01; end
      3: begin mr = 1; adr = 1; end
      4: begin rs = 2'b01; rw = 1; dn = 1; end
      5: begin mw = 1; adr = 1; dn = g; end
      6: begin sa = 2'b10; op = 2'b10; end
      7: begin
        sa = 2'b10; sb = 2'b01; op = 2'b11;
      end
      8: begin rw = 1; dn = 1; end
      9: begin
        sa = 2'b10; op = 2'b01; br = 1;
        pcw = z; dn = 1;
      end
      10: begin
        sa = 2'b01; sb = 2'b10; pcw = 1;
      end
      15: hl = 1;
      default: hl = 1;
    endcase
    return {pcw, irw, adr, mr, mw, rw, rs,
            sa, sb, op, br, dn, hl};
  endfunction

  function automatic logic [16:0] act_ctrl();
    return {bus.pc_write, bus.ir_write,
            bus.adr_src, bus.mem_read_en,
            bus.mem_write_en, bus.reg_write_en,
            bus.result_src, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op,
            bus.branch, bus.instr_done,
            bus.halted};
  endfunction

  // State walk an instruction class takes
  task automatic plan(input logic [6:0] op);
    seq.delete();
    case (op)
      OP_LD:   seq = '{0, 1, 2, 3, 4};
      OP_ST:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 8};
      OP_I:    seq = '{0, 1, 7, 8};
      OP_BEQ:  seq = '{0, 1, 9};
      OP_JAL:  seq = '{0, 1, 10, 8};
      default: seq = '{0, 1, 15};
    endcase
  endtask

  // Runs one instruction from a negedge in FETCH; returns at the
  // negedge after its last cycle. zmode<0 randomizes zero.
  task automatic run_instr(
    input  logic [6:0] op,
    input  bit         rand_ready,
    input  int         zmode,
    output int         cycles,
    output int         dones);
    int idx;
    bit stall;
    logic [16:0] e;
    plan(op);
    idx = 0;
    cycles = 0;
    dones = 0;
    bus.opcode = op;
    while (idx < seq.size()) begin
      bus.zero = (zmode < 0) ? 1'($urandom)
                             : 1'(zmode);
      if (rand_ready && cycles < 40)
        bus.mem_ready = ($urandom_range(0, 2) != 0);
      else
        bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== 4'(seq[idx])) begin
        errors++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d",
                 op, cycles, bus.state, seq[idx]);
      end
      e = exp_ctrl(seq[idx], bus.zero, bus.mem_ready);
      checks++;
      if (act_ctrl() !== e) begin
        errors++;
        $display("FAIL ctrl op=%b st=%0d got=%b exp=%b",
                 op, seq[idx], act_ctrl(), e);
      end
      dones += int'(bus.instr_done);
      cycles++;
      stall = WAIT_EN && !bus.mem_ready &&
              (seq[idx] inside {0, 3, 5});
      if (!stall) idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=0", bus.state);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_ctrl() !== exp_ctrl(0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               act_ctrl(), exp_ctrl(0, 1'b0, 1'b1));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_len(
    input string name, input int cycles,
    input int dones, input int exp_cyc);
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL %s_done got=%0d exp=1", name, dones);
    end
`ifndef MEM_WAIT_EN
    checks++;
    if (cycles !== exp_cyc) begin
      errors++;
      $display("FAIL %s_cycles got=%0d exp=%0d",
               name, cycles, exp_cyc);
    end
`endif
  endtask

  task automatic test_rtype();
    int c, d;
    run_instr(OP_R, 1'b0, -1, c, d);
    check_len("rtype", c, d, 4);
    run_instr(OP_I, 1'b0, -1, c, d);
    check_len("itype", c, d, 4);
  endtask

  task automatic test_load_store();
    int c, d;
    run_instr(OP_LD, 1'b0, -1, c, d);
    check_len("load", c, d, 5);
    run_instr(OP_ST, 1'b0, -1, c, d);
    check_len("store", c, d, 4);
  endtask

  task automatic test_beq();
    int c, d;
    run_instr(OP_BEQ, 1'b0, 1, c, d);
    check_len("beq_taken", c, d, 3);
    run_instr(OP_BEQ, 1'b0, 0, c, d);
    check_len("beq_not", c, d, 3);
  endtask

  task automatic test_jal();
    int c, d;
    run_instr(OP_JAL, 1'b0, -1, c, d);
    check_len("jal", c, d, 4);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    logic [6:0] op;
    int c, d, n;
    ops = '{OP_LD, OP_ST, OP_R, OP_I, OP_BEQ, OP_JAL};
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      run_instr(op, 1'b1, -1, c, d);
      n = (op == OP_LD) ? 5 : (op == OP_BEQ) ? 3 : 4;
      check_len("b2b", c, d, n);
    end
  endtask

  task automatic test_trap();
    int c, d;
    run_instr(7'b0000000, 1'b1, -1, c, d);
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 7'($urandom);
      bus.zero = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      #1;
      checks++;
      if (bus.state !== 4'd15 ||
          act_ctrl() !== exp_ctrl(15, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL trap_hold cyc=%0d st=%0d ctrl=%b",
                 i, bus.state, act_ctrl());
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL trap_reset got=%0d exp=0", bus.state);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    bus.opcode = OP_LD;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      checks++;
      if (bus.state !== 4'(s)) begin
        errors++;
        $display("FAIL abort_walk got=%0d exp=%0d",
                 bus.state, s);
      end
      if (s < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.reg_write_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset st=%0d rw=%b exp st=0 rw=0",
               bus.state, bus.reg_write_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.reg_write_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold st=%0d rw=%b exp st=0 rw=0",
               bus.state, bus.reg_write_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    bus.opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      #1;
      checks++;
      if (bus.state !== 4'd0 ||
          bus.pc_write !== 1'(i == 3) ||
          bus.ir_write !== 1'(i == 3)) begin
        errors++;
        $display("FAIL fetch_wait i=%0d st=%0d pcw=%b irw=%b",
                 i, bus.state, bus.pc_write, bus.ir_write);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL fetch_wait_exit got=%0d exp=1", bus.state);
    end
    #1 rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`else
  task automatic test_no_wait();
    int c, d;
    run_instr(OP_LD, 1'b1, -1, c, d);
    check_len("nowait_load", c, d, 5);
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_beq();
    test_jal();
    test_back_to_back();
    test_trap();
    test_reset_abort();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`else
    test_no_wait();
`endif
    test_jal();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
